// File: rtl/bounce_generator_pkg.sv
// Shared definitions for the contact-bounce emulator: FSM encoding, LFSR taps
// and the default LFSR seed.
package bounce_generator_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  // Taps 16,14,13,11 for a right-shifting Fibonacci register (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/bounce_generator_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; an all-zero state reloads the seed.
module lfsr16
  import bounce_generator_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= seed;
    end else if (q == '0) begin
      q <= seed;
    end else begin
      q <= {^(q & LFSR_TAPS), q[15:1]};
    end
  end

endmodule

// File: rtl/bounce_generator.sv
// Contact-bounce emulator: turns a clean switch level into a pseudo-randomly
// chattering contact for a bounded window, or passes it straight through.
module bounce_generator
  import bounce_generator_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 2000000,
  parameter int unsigned MIN_HOLD      = 16,
  parameter logic [15:0] SEED          = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       level,
  output logic       bouncy,
  output logic       busy,
  output logic [7:0] toggles
);

  localparam logic [23:0] WINDOW_LOAD = 24'(BOUNCE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LOAD   = 8'(MIN_HOLD - 1);

  state_t      state;
  logic        sync1;
  logic        level_s;
  logic        target;
  logic [23:0] window_cnt;
  logic [7:0]  hold_cnt;
  logic [15:0] lfsr_q;
  logic [8:0]  hold_sum;
  logic [7:0]  hold_reload;
  logic        lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:5];

  // Random extra hold of 0..15 cycles, clamped so large MIN_HOLD cannot wrap.
  assign hold_sum    = {1'b0, HOLD_LOAD} + {5'b0, lfsr_q[4:1]};
  assign hold_reload = hold_sum[8] ? 8'hFF : hold_sum[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sync1      <= 1'b0;
      level_s    <= 1'b0;
      target     <= 1'b0;
      bouncy     <= 1'b0;
      busy       <= 1'b0;
      toggles    <= '0;
      window_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      sync1   <= level;
      level_s <= sync1;
      case (state)
        IDLE: begin
          if (level_s != target) begin
            target <= level_s;
            if (en) begin
              state      <= BOUNCE;
              window_cnt <= WINDOW_LOAD;
              hold_cnt   <= HOLD_LOAD;
              toggles    <= '0;
              busy       <= 1'b1;
            end else begin
              bouncy <= level_s;
            end
          end
        end
        BOUNCE: begin
          // Window end or en falling wins over any toggle due this cycle.
          if (!en || window_cnt == '0) begin
            state  <= IDLE;
            bouncy <= target;
            busy   <= 1'b0;
          end else begin
            window_cnt <= window_cnt - 24'd1;
            hold_cnt   <= hold_cnt - 8'd1;
            if (hold_cnt == '0) begin
              hold_cnt <= hold_reload;
              if (lfsr_q[0]) begin
                bouncy <= ~bouncy;
                if (toggles != 8'hFF) toggles <= toggles + 8'd1;
              end
            end
            if (level_s != target) begin
              target     <= level_s;
              window_cnt <= WINDOW_LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_generator.sv
// Scoreboarded bench for bounce_generator: stimulus queues expected busy and
// pass-through events; a negedge monitor pops and checks them as they appear.
module tb_bounce_generator;

  localparam int unsigned BC = 100;
  localparam int unsigned MH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       level;
  logic       bouncy;
  logic       busy;
  logic [7:0] toggles;

  bounce_generator #(
    .BOUNCE_CYCLES (BC),
    .MIN_HOLD      (MH),
    .SEED          (16'hACE1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .level   (level),
    .bouncy  (bouncy),
    .busy    (busy),
    .toggles (toggles)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_RISE, EV_FALL, EV_PASS} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic        val;
    int unsigned cyc;
    bit          plain;
    bit          need_tog;
  } ev_t;

  ev_t         sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  logic        rst_edge = 1'b1;
  logic        lvl = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= reset;
  end

  task automatic check(input string name, input bit ok,
                       input int unsigned act, input int unsigned req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic        p_busy = 1'b0;
  logic        p_bouncy = 1'b0;
  int unsigned tog_obs = 0;
  int unsigned last_tog = 0;
  logic [7:0]  last_fall_tog = '0;
  logic        db_last = 1'b0;
  logic        db_out = 1'b0;
  int unsigned db_stable = 0;
  bit          db_pend = 0;
  int unsigned db_due = 0;
  logic        db_val = 1'b0;

  task automatic take(output bit got, output ev_t e);
    got = 0;
    e   = '{EV_RISE, 1'b0, 0, 0, 0};
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event at cycle %0d: got busy=%b bouncy=%b, required no event",
               cyc, busy, bouncy);
    end else begin
      e   = sb.pop_front();
      got = 1;
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit  got;
    // Behavioural debouncer: follows bouncy once it has been stable 8 samples.
    if (bouncy != db_last) db_stable = 0;
    else if (db_stable < 8) db_stable++;
    db_last = bouncy;
    if (db_stable >= 8) db_out = bouncy;

    if (rst_edge) begin
      tog_obs       = 0;
      db_pend       = 0;
      last_fall_tog = '0;
    end else begin
      if (!p_busy && busy) begin
        take(got, e);
        if (got) begin
          check("rise_kind", e.kind == EV_RISE, int'(e.kind), int'(EV_RISE));
          check("rise_cycle", cyc == e.cyc, cyc, e.cyc);
          check("rise_toggles_zero", toggles == 8'd0, toggles, 0);
        end
        tog_obs  = 0;
        last_tog = cyc;
      end else if (p_busy && !busy) begin
        take(got, e);
        if (got) begin
          check("fall_kind", e.kind == EV_FALL, int'(e.kind), int'(EV_FALL));
          check("fall_cycle", cyc == e.cyc, cyc, e.cyc);
          check("fall_bouncy", bouncy == e.val, bouncy, e.val);
          check("fall_toggles", toggles == 8'((tog_obs > 255) ? 255 : tog_obs),
                toggles, tog_obs);
          if (e.plain) check("plain_toggles_max", tog_obs <= 25, tog_obs, 25);
          if (e.need_tog) check("plain_toggles_min", tog_obs >= 1, tog_obs, 1);
          db_pend = 1;
          db_due  = cyc + 12;
          db_val  = e.val;
        end
        last_fall_tog = toggles;
      end else if (p_busy && busy && bouncy != p_bouncy) begin
        tog_obs++;
        check("toggle_spacing", (cyc - last_tog) >= MH, cyc - last_tog, MH);
        last_tog = cyc;
      end else if (!p_busy && !busy && bouncy != p_bouncy) begin
        take(got, e);
        if (got) begin
          check("pass_kind", e.kind == EV_PASS, int'(e.kind), int'(EV_PASS));
          check("pass_cycle", cyc == e.cyc, cyc, e.cyc);
          check("pass_value", bouncy == e.val, bouncy, e.val);
          check("pass_toggles_held", toggles == last_fall_tog, toggles, last_fall_tog);
        end
      end
      if (db_pend && cyc == db_due) begin
        check("debounce_settle", db_out == db_val, db_out, db_val);
        db_pend = 0;
      end
    end
    p_busy   = busy;
    p_bouncy = bouncy;
  end

  // ---------------- stimulus ----------------
  task automatic wait_to(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // kind 0: plain window, 1: retrigger back at offset p, 2: en drops at offset p
  task automatic scen(input bit en_v, input int kind, input int unsigned p, input bit need_tog);
    int unsigned s;
    logic        nv;
    nv    = ~lvl;
    en    = en_v;
    level = nv;
    lvl   = nv;
    s     = cyc;
    if (!en_v) begin
      sb.push_back('{EV_PASS, nv, s + 3, 0, 0});
      wait_to(s + 20);
      return;
    end
    sb.push_back('{EV_RISE, nv, s + 3, 0, 0});
    case (kind)
      0: begin
        sb.push_back('{EV_FALL, nv, s + BC + 3, 1, need_tog});
        wait_to(s + BC + 23);
      end
      1: begin
        wait_to(s + p);
        level = ~nv;
        lvl   = ~nv;
        sb.push_back('{EV_FALL, ~nv, s + p + BC + 3, 0, 0});
        wait_to(s + p + BC + 23);
      end
      default: begin
        wait_to(s + p);
        en = 1'b0;
        sb.push_back('{EV_FALL, nv, s + p + 1, 0, 0});
        wait_to(s + p + 20);
        en = 1'b1;
      end
    endcase
  endtask

  initial begin
    int unsigned s;
    reset = 1'b1;
    en    = 1'b1;
    level = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      check("idle_quiet", bouncy == 0 && busy == 0 && toggles == 0,
            {bouncy, busy, toggles}, 0);
    end

    scen(0, 0, 0, 0);     // pass-through 0->1
    scen(0, 0, 0, 0);     // pass-through 1->0
    scen(1, 0, 0, 1);     // bounce 0->1
    scen(1, 0, 0, 0);     // bounce 1->0
    scen(1, 1, 40, 0);    // 0->1 then back to 0 at cycle 40

    for (int i = 0; i < 12; i++) begin
      bit          ev;
      int          k;
      int unsigned p;
      ev = ($urandom_range(0, 3) != 0);
      k  = int'($urandom_range(0, 2));
      p  = (k == 1) ? $urandom_range(5, 90) : $urandom_range(10, 90);
      scen(ev, k, p, 0);
    end

    // Reset mid-window with level returned to 0: nothing may restart.
    if (lvl) scen(0, 0, 0, 0);
    en    = 1'b1;
    level = 1'b1;
    lvl   = 1'b1;
    s     = cyc;
    sb.push_back('{EV_RISE, 1'b1, s + 3, 0, 0});
    wait_to(s + 50);
    reset = 1'b1;
    level = 1'b0;
    lvl   = 1'b0;
    sb.delete();
    wait_to(s + 51);
    check("reset_abort", bouncy == 0 && busy == 0 && toggles == 0,
          {bouncy, busy, toggles}, 0);
    reset = 1'b0;
    wait_to(s + 200);

    // Reset held with level=1: one normal bounce toward 1 after release.
    reset = 1'b1;
    level = 1'b1;
    lvl   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", bouncy == 0 && busy == 0 && toggles == 0,
          {bouncy, busy, toggles}, 0);
    reset = 1'b0;
    s     = cyc;
    sb.push_back('{EV_RISE, 1'b1, s + 3, 0, 0});
    sb.push_back('{EV_FALL, 1'b1, s + BC + 3, 1, 0});
    wait_to(s + BC + 30);

    check("scoreboard_drained", sb.size() == 0, sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at cycle %0d: got no completion, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bounce_generator.md
BOUNCE_GENERATOR -- requirements
Module: bounce_generator

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 2000000, SHALL set the bounce window length in clk cycles (20 ms at 100 MHz); legal range 8..2^24-1.
REQ-002 Parameter MIN_HOLD, default 16, SHALL set the minimum cycles between candidate toggles; legal range 1..255.
REQ-003 Parameter SEED, default 16'hACE1, SHALL be the nonzero LFSR reset value.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  1 = bounce emulation, 0 = clean pass-through.
REQ-007 level  input  1  clean switch level, asynchronous to clk.
REQ-008 bouncy  output  1  emulated bouncing contact, registered.
REQ-009 busy  output  1  high while a bounce window is active.
REQ-010 toggles  output  8  toggles emitted in the current or last window, saturating at 255.

Function
REQ-011 level SHALL pass through a 2-flop synchronizer; level_s denotes its output, 2 cycles after level.
REQ-012 A registered target bit SHALL hold the last settled level; FSM states SHALL be IDLE and BOUNCE.
REQ-013 IDLE: bouncy = target; busy = 0.
REQ-014 IDLE with en=1 and level_s != target: next cycle enter BOUNCE, target <= level_s, window counter <= BOUNCE_CYCLES-1, hold counter <= MIN_HOLD-1, toggles <= 0, busy = 1.
REQ-015 IDLE with en=0 and level_s != target: target <= level_s, bouncy <= level_s next cycle, toggles unchanged, no BOUNCE.
REQ-016 BOUNCE: window and hold counters SHALL decrement by 1 each cycle.
REQ-017 BOUNCE, hold counter = 0: bouncy SHALL invert if lfsr[0]=1, else hold; toggles += 1 on inversion, saturating at 255; hold counter <= MIN_HOLD-1 + lfsr[4:1].
REQ-018 BOUNCE, window counter = 0: bouncy <= target, busy <= 0, return to IDLE; this overrides a same-cycle toggle per REQ-017.
REQ-019 BOUNCE, level_s != target (retrigger): target <= level_s, window counter reloads to BOUNCE_CYCLES-1, toggles continue counting.
REQ-020 BOUNCE, en falls to 0: next cycle bouncy <= target, busy <= 0, IDLE.
REQ-021 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle regardless of state; an all-zero state SHALL reload SEED.
REQ-022 Once en=1 and level_s is stable, bouncy SHALL equal level_s no later than BOUNCE_CYCLES+1 cycles after level_s changes.

Reset
REQ-023 On reset=1 at a clk edge: state IDLE, bouncy=0, target=0, busy=0, toggles=0, counters=0, synchronizer flops=0, LFSR=SEED.
REQ-024 Reset asserted mid-BOUNCE SHALL abort the window with the REQ-023 values on the next cycle.
REQ-025 After reset release with level held at 1, the design SHALL perform one normal bounce event toward 1 (en=1) or pass-through (en=0).

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=1'b0, BOUNCE=1'b1), the LFSR tap mask, and the default SEED.
REQ-027 The LFSR SHALL be a separate sub-module, lfsr16 (ports clk, reset, seed, q[15:0]); all other logic stays in bounce_generator.
REQ-028 Counter widths SHALL be 24 bits for the window counter and 8 bits for the hold counter.

Verification (BOUNCE_CYCLES=100, MIN_HOLD=4, SEED=16'hACE1)
REQ-029 Reset, en=1, level=0 for 50 cycles -> bouncy=0, busy=0, toggles=0 throughout.
REQ-030 en=1, level 0->1 -> busy rises 3 cycles after level; bouncy settles to 1 exactly 103 cycles after level; toggles in 1..25; consecutive toggle spacing >= 4 cycles.
REQ-031 en=0, level 0->1 -> bouncy=1 exactly 3 cycles after level; busy never asserts; toggles unchanged.
REQ-032 en=1, level 0->1, then 1->0 at cycle 40 -> window restarts; bouncy settles to 0 at cycle 143; busy high continuously from cycle 3 to 142.
REQ-033 en=1, rising level, reset pulsed at cycle 50 -> cycle 51 shows bouncy=0, busy=0, toggles=0, and no bounce event resumes while level_s=0 is held.
REQ-034 Scoreboard: at every busy fall, bouncy == target, and an attached debounce instance settles to the same value.
